// File: rtl/mux4to1_10bits_rr.sv
`default_nettype none
// ============================================================================
// Module  : mux4to1_10bits_rr
// Brief   : 4-channel valid/ready collector onto one registered, tagged output.
//           Define MUX_RR_ARB_EN for round-robin; otherwise fixed A>B>C>D.
// Rev     : 1.0  initial release
// ============================================================================
module mux4to1_10bits_rr #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [3:0]       valid_in,
  output logic [3:0]       ready_in,
  output logic [WIDTH-1:0] X,
  output logic [1:0]       select,
  output logic             valid_out,
  input  logic             ready_out
);

  logic [WIDTH-1:0] x_q, x_d;
  logic [1:0]       select_q, select_d;
  logic             valid_q, valid_d;
  logic [1:0]       search_base;

  logic             w_load;
  logic             w_found;
  logic [1:0]       w_gnt_idx;
  logic             w_xfer;
  logic [WIDTH-1:0] w_gnt_data;

`ifdef MUX_RR_ARB_EN
  logic [1:0] ptr_q, ptr_d;

  assign search_base = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (w_xfer) begin
      ptr_d = w_gnt_idx + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign search_base = 2'd0;
`endif

  assign w_load = ~valid_q | ready_out;

  // First valid channel at or after the search base, wrapping modulo 4.
  always_comb begin : p_grant
    logic [1:0] idx;
    w_found   = 1'b0;
    w_gnt_idx = 2'd0;
    idx       = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = search_base + 2'(k);
      if (!w_found && valid_in[idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = idx;
      end
    end
  end

  always_comb begin
    unique case (w_gnt_idx)
      2'd0:    w_gnt_data = A;
      2'd1:    w_gnt_data = B;
      2'd2:    w_gnt_data = C;
      default: w_gnt_data = D;
    endcase
  end

  // Reset gates ready so no channel believes a transfer completed at a reset edge.
  assign w_xfer = w_load & w_found & ~reset;

  always_comb begin
    ready_in = 4'b0000;
    if (w_xfer) begin
      ready_in[w_gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    x_d      = x_q;
    select_d = select_q;
    valid_d  = valid_q;
    if (w_load) begin
      if (w_found) begin
        x_d      = w_gnt_data;
        select_d = w_gnt_idx;
        valid_d  = 1'b1;
      end else begin
        valid_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q      <= '0;
      select_q <= 2'd0;
      valid_q  <= 1'b0;
    end else begin
      x_q      <= x_d;
      select_q <= select_d;
      valid_q  <= valid_d;
    end
  end

  assign X         = x_q;
  assign select    = select_q;
  assign valid_out = valid_q;

endmodule
`default_nettype wire
